aes_stream_packer: RTL

- Byte-stream front/back end for the iterative 128-bit AES encryption core.
- Packs an input byte stream into 128-bit blocks and applies PKCS#7 padding to the final block.
- Drives the core's start/ready handshake, captures each cipher block and serialises it back out as bytes.
- Sits directly upstream and downstream of the core, between the password-record byte interface and the cipher engine.

---
 rtl/aes_stream_packer_if.sv | 37 +++
 rtl/aes_stream_packer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/aes_stream_packer_if.sv
// Byte-in / AES-core / byte-out signal bundle for aes_stream_packer.
// master = packer side, slave = environment (source, core, sink).
interface aes_stream_packer_if #(
    parameter int CNT_W = 16
);
    logic [127:0]     key_in;
    logic             key_load;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [127:0]     aes_plaintext;
    logic [127:0]     aes_key;
    logic             aes_start;
    logic             aes_ready;
    logic [127:0]     aes_cipher;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic [CNT_W-1:0] block_count;
    logic             error;

    modport master (
        input  key_in, key_load, in_byte, in_valid, in_last,
               aes_ready, aes_cipher, out_ready,
        output in_ready, aes_plaintext, aes_key, aes_start,
               out_byte, out_valid, out_last, block_count, error
    );

    modport slave (
        output key_in, key_load, in_byte, in_valid, in_last,
               aes_ready, aes_cipher, out_ready,
        input  in_ready, aes_plaintext, aes_key, aes_start,
               out_byte, out_valid, out_last, block_count, error
    );
endinterface

// File: rtl/aes_stream_packer.sv
// Packs bytes into PKCS#7-padded 128-bit blocks, runs the AES core, serialises cipher bytes (CBC via AES_STREAM_CBC_EN).
// Latency: full block -> aes_start next cycle, partial block +1 cycle for padding; first out byte the cycle after aes_ready.
// Backpressure: in_ready only while filling; out_ready=0 holds the drain and stalls the whole stream.
module aes_stream_packer #(
    parameter int WAIT_LIMIT = 31,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    aes_stream_packer_if.master bus
);

    localparam int TMR_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {FILL, PAD, START, WAIT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [3:0]       n_q;
    logic [3:0]       oidx_q;
    logic [TMR_W-1:0] tmr_q;
    logic [127:0]     blk_q;
    logic [127:0]     obuf_q;
    logic [127:0]     key_q;
    logic [CNT_W-1:0] blk_cnt_q;
    logic             pad_pending_q;
    logic             msg_end_q;
    logic             alive_q;
    logic             error_q;

    logic             in_fire;
    logic             out_fire;
    logic             key_ok;
    logic             capture;
    logic             timeout;
    logic [7:0]       pad_val;

    assign in_fire  = (state_q == FILL) && alive_q && bus.in_valid;
    assign out_fire = (state_q == DRAIN) && bus.out_ready;
    assign key_ok   = (state_q == FILL) && (n_q == 4'd0) && bus.key_load;
    assign capture  = (state_q == WAIT) && bus.aes_ready;
    assign timeout  = (state_q == WAIT) && !bus.aes_ready
                      && (tmr_q == TMR_W'(WAIT_LIMIT - 1));
    assign pad_val  = 8'd16 - {4'd0, n_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (n_q == 4'd15)     state_d = START;
                    else if (bus.in_last) state_d = PAD;
                end
            end
            PAD:   state_d = START;
            START: state_d = WAIT;
            WAIT: begin
                if (capture)      state_d = DRAIN;
                else if (timeout) state_d = FILL;
            end
            DRAIN: begin
                if (out_fire && (oidx_q == 4'd15))
                    state_d = pad_pending_q ? START : FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == FILL) && alive_q;
        bus.aes_start = (state_q == START);
        bus.out_valid = (state_q == DRAIN);
        bus.out_last  = (state_q == DRAIN) && msg_end_q && (oidx_q == 4'd15);
    end

    assign bus.aes_key     = key_q;
    assign bus.out_byte    = obuf_q[{~oidx_q, 3'b000} +: 8];
    assign bus.block_count = blk_cnt_q;
    assign bus.error       = error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q           <= '0;
            oidx_q        <= '0;
            tmr_q         <= '0;
            blk_q         <= '0;
            obuf_q        <= '0;
            key_q         <= '0;
            blk_cnt_q     <= '0;
            pad_pending_q <= 1'b0;
            msg_end_q     <= 1'b0;
            alive_q       <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (key_ok) key_q <= bus.key_in;
            case (state_q)
                FILL: begin
                    if (in_fire) begin
                        // n wraps to 0 on the 16th byte, ready for the next block
                        blk_q[{~n_q, 3'b000} +: 8] <= bus.in_byte;
                        n_q           <= n_q + 4'd1;
                        msg_end_q     <= bus.in_last && (n_q != 4'd15);
                        pad_pending_q <= bus.in_last && (n_q == 4'd15);
                    end
                end
                PAD: begin
                    for (int i = 0; i < 16; i++) begin
                        if (i >= int'(n_q)) blk_q[8*(15-i) +: 8] <= pad_val;
                    end
                    n_q <= '0;
                end
                START: tmr_q <= TMR_W'(1);
                WAIT: begin
                    if (capture) begin
                        obuf_q    <= bus.aes_cipher;
                        blk_cnt_q <= blk_cnt_q + 1'b1;
                        oidx_q    <= '0;
                    end else if (timeout) begin
                        error_q       <= 1'b1;
                        n_q           <= '0;
                        pad_pending_q <= 1'b0;
                        msg_end_q     <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        oidx_q <= oidx_q + 4'd1;
                        if ((oidx_q == 4'd15) && pad_pending_q) begin
                            blk_q         <= {16{8'h10}};
                            pad_pending_q <= 1'b0;
                            msg_end_q     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AES_STREAM_CBC_EN
    logic [127:0] iv_q;
    logic [127:0] chain_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iv_q    <= '0;
            chain_q <= '0;
        end else if (key_ok) begin
            iv_q    <= bus.key_in ^ 128'h1;
            chain_q <= bus.key_in ^ 128'h1;
        end else if (capture) begin
            chain_q <= bus.aes_cipher;
        end else if (out_fire && (oidx_q == 4'd15) && msg_end_q) begin
            // message finished: next message starts a fresh chain
            chain_q <= iv_q;
        end
    end

    assign bus.aes_plaintext = blk_q ^ chain_q;
`else
    assign bus.aes_plaintext = blk_q;
`endif

endmodule
